sd_frame_packer: RTL
====================

Name: sd_frame_packer

Overview:
- Parametrised byte-to-pixel packer between the SD card SPI reader and the SDRAM write FIFO of the picture-display path.
- Consumes the raw BMP byte stream from the SD reader and skips a configurable header.
- Assembles 16-bit or 24-bit pixels, converts them to RGB565 and strips BMP 4-byte row padding.
- Emits exactly H_DISP*V_DISP words per frame, with line index and last flag, over a valid/ready handshake.

Parameters:
- H_DISP, 480, active pixels per line
- V_DISP, 272, lines per frame
- HDR_BYTES, 54, header bytes discarded before pixel data (0 allowed)
- BOTTOM_UP, 1, 1: first stored row is line V_DISP-1 (BMP order); 0: first row is line 0

Ports:
- clk  in  1  system clock (SDRAM controller clock domain)
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse; begins a frame; ignored unless idle
- bpp_sel  in  1  sampled on start; 0 = 16-bit RGB565 little-endian input, 1 = 24-bit BGR888 input
- in_valid  in  1  SD byte valid
- in_data  in  8  SD byte
- in_ready  out  1  byte accepted when in_valid && in_ready
- out_valid  out  1  pixel word valid
- out_data  out  16  RGB565 pixel
- out_y  out  clog2(V_DISP)  display line of out_data
- out_last  out  1  qualifies the final pixel of the frame
- out_ready  in  1  downstream (FIFO not almost-full)
- busy  out  1  high from the cycle after an accepted start until frame_done
- frame_done  out  1  one-cycle pulse when the frame is complete

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_data=0, out_y=0, out_last=0, busy=0, frame_done=0, state=IDLE, all counters 0. Reset mid-frame aborts immediately; partial pixel data is discarded.
- Per-frame constants:
  - bpp = bpp_sel ? 3 : 2
  - row_bytes = H_DISP*bpp
  - pad = (4 - row_bytes mod 4) mod 4
- States: IDLE, HDR, PIX, PAD, FLUSH.
- IDLE: in_ready=0. On start, latch bpp_sel, clear counters, set busy, and go to HDR (or PIX if HDR_BYTES=0).
- HDR: in_ready=1. Count accepted bytes; on acceptance of byte HDR_BYTES-1, go to PIX. Header bytes never reach the output.
- PIX: in_ready = !out_valid || out_ready. Byte index b runs 0..bpp-1.
  - Bytes are held in a 2-byte shift holding register.
  - On the final byte, load out_data and set out_valid in the next cycle (latency 1 from last-byte acceptance).
  - 16-bit mode: out_data = {byte1, byte0}.
  - 24-bit mode (byte0=B, byte1=G, byte2=R): out_data = {R[7:3], G[7:2], B[7:3]}.
  - out_valid is held with out_data stable until out_ready. Full throughput is 1 byte per clk.
- Column counter x runs 0..H_DISP-1, advancing when each pixel is formed. At x = H_DISP-1: if pad>0 go to PAD, else advance the row (or FLUSH if this was the last row).
- PAD: in_ready=1. Discard pad bytes, then advance the row or go to FLUSH. The last row's padding is consumed before FLUSH.
- Row counter r runs 0..V_DISP-1. out_y = BOTTOM_UP ? V_DISP-1-r : r. out_last=1 only with the pixel at r=V_DISP-1, x=H_DISP-1.
- FLUSH: in_ready=0. Wait until the out_last word handshakes. Then pulse frame_done, clear busy and go to IDLE.
- Bytes offered while in_ready=0 are not consumed; the source holds them.
- start while busy is ignored and does not corrupt state.
- Simultaneous out_ready and last-byte acceptance: the old word retires and the new word loads in the same cycle (no bubble).
- Counter widths are derived from the parameters. HDR_BYTES up to 2^16-1 must not overflow.

Decomposition:
- Shared package sd_frame_pkg holds:
  - state enum
  - function rgb888_to_565
  - function row_pad(bytes) returning the 0..3 pad count
  - constant for BPP_16 = 2 and BPP_24 = 3
- No sub-module is needed; the block is a single FSM with datapath, about 200 RTL lines.

Test Plan:
- 24bpp, H_DISP=5, V_DISP=2, HDR_BYTES=4, BOTTOM_UP=1; 4 header bytes + 2*(15+1 pad) bytes, out_ready=1 -> 10 words; first word out_y=1, word 6 out_y=0; out_last only on word 10; frame_done 1 cycle after its handshake.
- 24bpp pixel bytes B=0xFF, G=0x00, R=0x80 -> out_data=0x801F, out_valid 1 cycle after the R byte is accepted.
- 16bpp, H_DISP=5 (row 10 bytes, pad 2); bytes 0x34,0x12 -> 0x1234; both pad bytes per row discarded; exactly 10 words emitted.
- out_ready held low for 20 cycles mid-line -> out_data stable, in_ready=0 after the next pixel's final byte, no byte lost or duplicated once out_ready returns.
- start pulsed during PIX, then rst asserted 3 pixels later -> second start ignored; after reset all outputs are 0, and a new start produces a clean full frame.
- HDR_BYTES=0, BOTTOM_UP=0 -> first data byte is a pixel byte; out_y counts 0..V_DISP-1.

Source files
------------

// File: rtl/sd_frame_packer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sd_frame_pkg
//  Purpose  : Shared types and helpers for the SD-card BMP frame packer.
//             Holds the packer state encoding, the per-pixel byte counts,
//             the RGB888 -> RGB565 reduction and the BMP row-padding helper.
//  Revision : 1.0 - initial release
// ============================================================================
package sd_frame_pkg;

    // Bytes per pixel for the two supported BMP depths
    localparam int BPP_16 = 2;
    localparam int BPP_24 = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_PIX   = 3'd2,
        ST_PAD   = 3'd3,
        ST_FLUSH = 3'd4
    } state_t;

    // Keep the top bits of each channel: 5 red, 6 green, 5 blue
    function automatic logic [15:0] rgb888_to_565(input logic [7:0] r,
                                                  input logic [7:0] g,
                                                  input logic [7:0] b);
        return {r[7:3], g[7:2], b[7:3]};
    endfunction

    // BMP rows are padded to a multiple of 4 bytes; returns 0..3
    function automatic logic [1:0] row_pad(input int bytes);
        return 2'((4 - (bytes % 4)) % 4);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sd_frame_packer.sv
`default_nettype none
// ============================================================================
//  Module   : sd_frame_packer
//  Purpose  : Converts the raw BMP byte stream from the SD reader into
//             RGB565 display words. Skips HDR_BYTES of header, assembles
//             16-bit (RGB565 LE) or 24-bit (BGR888) pixels, drops the
//             4-byte row padding and emits H_DISP*V_DISP words per frame
//             tagged with the display line and a last-pixel flag.
//  Ports    : clk, rst         - clock, synchronous active-high reset
//             start, bpp_sel   - frame start pulse, depth select (1 = 24bpp)
//             in_valid/in_ready/in_data    - SD byte stream
//             out_valid/out_ready/out_data - RGB565 pixel stream
//             out_y, out_last  - display line and end-of-frame qualifier
//             busy, frame_done - frame in progress / completion pulse
//  Revision : 1.0 - initial release
// ============================================================================
module sd_frame_packer
    import sd_frame_pkg::*;
#(
    parameter int H_DISP    = 480,
    parameter int V_DISP    = 272,
    parameter int HDR_BYTES = 54,
    parameter int BOTTOM_UP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        bpp_sel,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [15:0] out_data,
    output logic [((V_DISP > 1) ? $clog2(V_DISP) : 1)-1:0] out_y,
    output logic        out_last,
    input  logic        out_ready,
    output logic        busy,
    output logic        frame_done
);

    localparam int c_x_w = (H_DISP > 1) ? $clog2(H_DISP) : 1;
    localparam int c_y_w = (V_DISP > 1) ? $clog2(V_DISP) : 1;
    localparam int c_h_w = (HDR_BYTES > 1) ? $clog2(HDR_BYTES) : 1;

    localparam logic [c_x_w-1:0] c_x_last   = c_x_w'(H_DISP - 1);
    localparam logic [c_y_w-1:0] c_r_last   = c_y_w'(V_DISP - 1);
    localparam logic [c_h_w-1:0] c_hdr_last = c_h_w'((HDR_BYTES > 0) ? HDR_BYTES - 1 : 0);
    localparam logic [1:0]       c_pad16    = row_pad(H_DISP * BPP_16);
    localparam logic [1:0]       c_pad24    = row_pad(H_DISP * BPP_24);

    state_t             r_state;
    logic               r_bpp24;
    logic [c_h_w-1:0]   r_hdr_cnt;
    logic [1:0]         r_b;
    logic [15:0]        r_hold;
    logic [c_x_w-1:0]   r_x;
    logic [c_y_w-1:0]   r_r;
    logic [1:0]         r_pad_cnt;

    logic               w_accept;
    logic               w_last_byte;
    logic               w_row_end;
    logic               w_last_row;
    logic               w_out_free;
    logic [1:0]         w_pad;
    logic [15:0]        w_pixel;
    logic [c_y_w-1:0]   w_y;

    // The output slot is free when empty or retiring this cycle, which lets
    // a new word load in the same cycle the old one handshakes.
    assign w_out_free  = !out_valid || out_ready;
    assign w_accept    = in_valid && in_ready;
    assign w_last_byte = r_bpp24 ? (r_b == 2'd2) : (r_b == 2'd1);
    assign w_row_end   = (r_x == c_x_last);
    assign w_last_row  = (r_r == c_r_last);
    assign w_pad       = r_bpp24 ? c_pad24 : c_pad16;
    assign w_y         = (BOTTOM_UP != 0) ? (c_r_last - r_r) : r_r;

    // r_hold is a 2-byte shift register: for 24bpp it holds {B, G} when R
    // arrives; for 16bpp its low byte holds the low pixel byte.
    assign w_pixel = r_bpp24 ? rgb888_to_565(in_data, r_hold[7:0], r_hold[15:8])
                             : {in_data, r_hold[7:0]};

    always_comb begin
        in_ready = 1'b0;
        case (r_state)
            ST_HDR, ST_PAD: in_ready = 1'b1;
            ST_PIX:         in_ready = w_out_free;
            default:        in_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_bpp24    <= 1'b0;
            r_hdr_cnt  <= '0;
            r_b        <= '0;
            r_hold     <= '0;
            r_x        <= '0;
            r_r        <= '0;
            r_pad_cnt  <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_y      <= '0;
            out_last   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_bpp24   <= bpp_sel;
                        r_hdr_cnt <= '0;
                        r_b       <= '0;
                        r_x       <= '0;
                        r_r       <= '0;
                        r_pad_cnt <= '0;
                        busy      <= 1'b1;
                        r_state   <= (HDR_BYTES == 0) ? ST_PIX : ST_HDR;
                    end
                end

                ST_HDR: begin
                    if (w_accept) begin
                        if (r_hdr_cnt == c_hdr_last) begin
                            r_state <= ST_PIX;
                        end else begin
                            r_hdr_cnt <= r_hdr_cnt + c_h_w'(1);
                        end
                    end
                end

                ST_PIX: begin
                    if (w_accept) begin
                        r_hold <= {r_hold[7:0], in_data};
                        if (w_last_byte) begin
                            r_b       <= '0;
                            out_valid <= 1'b1;
                            out_data  <= w_pixel;
                            out_y     <= w_y;
                            out_last  <= w_row_end && w_last_row;
                            if (w_row_end) begin
                                r_x <= '0;
                                if (w_pad != 2'd0) begin
                                    r_pad_cnt <= '0;
                                    r_state   <= ST_PAD;
                                end else if (w_last_row) begin
                                    r_state <= ST_FLUSH;
                                end else begin
                                    r_r <= r_r + c_y_w'(1);
                                end
                            end else begin
                                r_x <= r_x + c_x_w'(1);
                            end
                        end else begin
                            r_b <= r_b + 2'd1;
                        end
                    end
                end

                ST_PAD: begin
                    if (w_accept) begin
                        if (r_pad_cnt == (w_pad - 2'd1)) begin
                            r_pad_cnt <= '0;
                            if (w_last_row) begin
                                // Last word may already be gone (or going now);
                                // only wait in FLUSH if it is still stalled.
                                if (w_out_free) begin
                                    frame_done <= 1'b1;
                                    busy       <= 1'b0;
                                    r_state    <= ST_IDLE;
                                end else begin
                                    r_state <= ST_FLUSH;
                                end
                            end else begin
                                r_r     <= r_r + c_y_w'(1);
                                r_state <= ST_PIX;
                            end
                        end else begin
                            r_pad_cnt <= r_pad_cnt + 2'd1;
                        end
                    end
                end

                ST_FLUSH: begin
                    if (w_out_free) begin
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
